// File: rtl/mux4_arbiter_pkg.sv
// Shared types and helpers for the mux4_arbiter block.
package mux4_arbiter_pkg;

  localparam int NSRC = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  // Source index to one-hot grant vector (bit i == source i).
  function automatic logic [0:NSRC-1] idx2onehot(input logic [1:0] idx);
    logic [0:NSRC-1] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux4_rr_pick.sv
// Combinational winner selection for mux4_arbiter.
// Default: round-robin scan starting at LAST+1.
// MUX4_ARBITER_FIXED_PRIO_EN: lowest-index requester wins, LAST ignored.
module mux4_rr_pick
  import mux4_arbiter_pkg::*;
(
  input  logic [0:NSRC-1] REQ,
  input  logic [0:1]      LAST,
  output logic            ANY,
  output logic [0:1]      W
);

  assign ANY = |REQ;

`ifdef MUX4_ARBITER_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^LAST;

  // Walk from the highest index down so the lowest set bit is written last.
  always_comb begin
    W = 2'd0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (REQ[i]) W = 2'(i);
  end
`else
  logic [1:0] idx;

  // Walk the scan order backwards (LAST+4 .. LAST+1) so LAST+1 has final say.
  always_comb begin
    W   = LAST;
    idx = 2'd0;
    for (int k = NSRC; k >= 1; k--) begin
      idx = LAST + 2'(k);
      if (REQ[idx]) W = idx;
    end
  end
`endif

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin sequencer for a shared dual 1-of-4 mux path.
// Bounded bursts per grant, optional EN-low turnaround between owners.
// Optional: MUX4_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority.
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int BURST_MAX   = 4,
  parameter int TURN_CYCLES = 1,
  parameter int CW          = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [0:3]    REQ,
  output logic [0:1]    SEL,
  output logic          EN,
  output logic [0:3]    GNT,
  output logic [CW-1:0] BEAT,
  output logic          BUSY
);

  localparam logic [CW-1:0] BEAT_LAST = CW'(BURST_MAX);
  localparam logic [1:0]    TURN_LOAD = (TURN_CYCLES > 0) ? 2'(TURN_CYCLES - 1) : 2'd0;

  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      turn_q, turn_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic            en_q, en_d;
  logic [0:NSRC-1] gnt_q, gnt_d;
  logic            busy_q, busy_d;

  logic            arb;
  logic            pick_any;
  logic [0:1]      pick_w;
  logic [0:1]      pick_last;

  // While granting, the only arbitration is at grant end, where LAST is
  // already the current owner; feed that through so TURN_CYCLES=0 works.
  assign pick_last = (state_q == GRANT) ? sel_q : last_q;

  mux4_rr_pick u_pick (
    .REQ  (REQ),
    .LAST (pick_last),
    .ANY  (pick_any),
    .W    (pick_w)
  );

  // Next-state, beat counting and registered output decode.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    beat_d  = beat_q;
    last_d  = last_q;
    turn_d  = turn_q;
    arb     = 1'b0;
    case (state_q)
      IDLE: arb = 1'b1;
      GRANT: begin
        if (REQ[sel_q] && ((beat_q + CW'(1)) != BEAT_LAST)) begin
          beat_d = beat_q + CW'(1);
        end else begin
          // Request dropped or burst exhausted: one end-of-grant either way.
          last_d = sel_q;
          beat_d = '0;
          if (TURN_CYCLES > 0) begin
            state_d = TURN;
            turn_d  = TURN_LOAD;
          end else begin
            arb = 1'b1;
          end
        end
      end
      TURN: begin
        if (turn_q == 2'd0) arb = 1'b1;
        else                turn_d = turn_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
    if (arb) begin
      if (pick_any) begin
        state_d = GRANT;
        sel_d   = pick_w;
        beat_d  = '0;
      end else begin
        state_d = IDLE;
      end
    end
    en_d   = (state_d == GRANT);
    gnt_d  = en_d ? idx2onehot(sel_d) : '0;
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset leaves LAST=3 so source 0 goes first.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      beat_q  <= '0;
      last_q  <= 2'd3;
      turn_q  <= 2'd0;
      en_q    <= 1'b0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      turn_q  <= turn_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign SEL  = sel_q;
  assign EN   = en_q;
  assign GNT  = gnt_q;
  assign BEAT = beat_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Scoreboard bench for mux4_arbiter: three configurations share REQ/RESET,
// a behavioural model predicts every cycle, a monitor compares at negedge.
module tb_mux4_arbiter;

  logic       clk = 1'b0;
  logic       RESET;
  logic [0:3] req;

  always #5 clk = ~clk;

  logic [0:1] sel_o  [3];
  logic       en_o   [3];
  logic [0:3] gnt_o  [3];
  logic [3:0] beat_o [3];
  logic       busy_o [3];

  mux4_arbiter #(.BURST_MAX(4), .TURN_CYCLES(1), .CW(4)) u_dut_a (
    .CLK(clk), .RESET(RESET), .REQ(req), .SEL(sel_o[0]), .EN(en_o[0]),
    .GNT(gnt_o[0]), .BEAT(beat_o[0]), .BUSY(busy_o[0]));
  mux4_arbiter #(.BURST_MAX(2), .TURN_CYCLES(1), .CW(4)) u_dut_b (
    .CLK(clk), .RESET(RESET), .REQ(req), .SEL(sel_o[1]), .EN(en_o[1]),
    .GNT(gnt_o[1]), .BEAT(beat_o[1]), .BUSY(busy_o[1]));
  mux4_arbiter #(.BURST_MAX(4), .TURN_CYCLES(0), .CW(4)) u_dut_c (
    .CLK(clk), .RESET(RESET), .REQ(req), .SEL(sel_o[2]), .EN(en_o[2]),
    .GNT(gnt_o[2]), .BEAT(beat_o[2]), .BUSY(busy_o[2]));

  function automatic int bm(input int i);
    return (i == 1) ? 2 : 4;
  endfunction
  function automatic int tc(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  // owner = -1 when nobody holds the path; gap = dead cycles still owed.
  typedef struct {
    int owner;
    int beats;
    int gap;
    int last;
    int sel;
  } mdl_t;

  typedef struct {
    int         inst;
    int         en;
    int         sel;
    logic [0:3] gnt;
    int         beat;
    int         busy;
  } exp_t;

  mdl_t m [3];
  exp_t q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic mdl_t mreset();
    mdl_t r;
    r.owner = -1; r.beats = 0; r.gap = 0; r.last = 3; r.sel = 0;
    return r;
  endfunction

  function automatic int pick(input logic [0:3] r, input int last);
    int w;
    w = -1;
`ifdef MUX4_ARBITER_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) if (r[i]) w = i;
`else
    for (int k = 4; k >= 1; k--) if (r[(last + k) % 4]) w = (last + k) % 4;
`endif
    return w;
  endfunction

  function automatic mdl_t step(input mdl_t c, input logic [0:3] r, input int bmax, input int turn);
    mdl_t n;
    bit   arb;
    int   w;
    n   = c;
    arb = 1'b0;
    if (c.owner >= 0) begin
      if (r[c.owner]) n.beats = c.beats + 1;
      if (!r[c.owner] || n.beats == bmax) begin
        n.last  = c.owner;
        n.owner = -1;
        n.beats = 0;
        if (turn > 0) n.gap = turn;
        else          arb = 1'b1;
      end
    end else if (c.gap > 0) begin
      n.gap = c.gap - 1;
      arb   = (n.gap == 0);
    end else begin
      arb = 1'b1;
    end
    if (arb) begin
      w = pick(r, n.last);
      if (w >= 0) begin
        n.owner = w;
        n.sel   = w;
        n.beats = 0;
      end
    end
    return n;
  endfunction

  task automatic push_all();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e.inst = i;
      e.en   = (m[i].owner >= 0);
      e.sel  = m[i].sel;
      e.gnt  = '0;
      if (m[i].owner >= 0) e.gnt[m[i].owner] = 1'b1;
      e.beat = m[i].beats;
      e.busy = (m[i].owner >= 0) || (m[i].gap > 0);
      q.push_back(e);
    end
  endtask

  // One clock: REQ applied before the edge, model stepped on it, optional
  // asynchronous reset asserted mid-cycle (expectation becomes reset values).
  task automatic cyc(input logic [0:3] r, input bit rst_mid);
    req = r;
    @(posedge clk);
    if (rst_mid) begin
      #2;
      RESET = 1'b1;
    end
    for (int i = 0; i < 3; i++)
      m[i] = RESET ? mreset() : step(m[i], r, bm(i), tc(i));
    push_all();
    #1;
  endtask

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, inst, $time, act, expv);
    end
  endtask

  // Monitor: every negedge drain whatever the stimulus predicted for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("en",   e.inst, 32'(en_o[e.inst]),   32'(e.en));
        chk("sel",  e.inst, 32'(sel_o[e.inst]),  32'(e.sel));
        chk("gnt",  e.inst, 32'(gnt_o[e.inst]),  32'(e.gnt));
        chk("beat", e.inst, 32'(beat_o[e.inst]), 32'(e.beat));
        chk("busy", e.inst, 32'(busy_o[e.inst]), 32'(e.busy));
      end
    end
  end

  initial begin
    logic [0:3] r;
    RESET = 1'b1;
    req   = '0;
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    RESET = 1'b0;

    // Single requester, source 2, dropped after a short burst.
    r = '0; r[2] = 1'b1;
    repeat (3) cyc(r, 1'b0);
    repeat (4) cyc(4'b0000, 1'b0);

    // All sources, then sources 0 and 3, then source 1 alone.
    repeat (26) cyc(4'b1111, 1'b0);
    repeat (4)  cyc(4'b0000, 1'b0);
    repeat (20) cyc(4'b1001, 1'b0);
    repeat (4)  cyc(4'b0000, 1'b0);
    repeat (15) cyc(4'b0100, 1'b0);
    repeat (3)  cyc(4'b0000, 1'b0);

    // Fixed-priority-style contention between sources 1 and 2.
    repeat (20) cyc(4'b0110, 1'b0);

    // Reset mid-grant at BEAT=2, then source 0 alone after release.
    cyc(4'b0000, 1'b1);
    RESET = 1'b0;
    cyc(4'b1111, 1'b0);
    cyc(4'b1111, 1'b0);
    cyc(4'b1111, 1'b1);
    RESET = 1'b0;
    repeat (6) cyc(4'b1000, 1'b0);

    // Randomized traffic with held requests and occasional mid-cycle resets.
    r = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      cyc(r, ($urandom_range(0, 149) == 0));
      if (RESET && ($urandom_range(0, 1) == 1)) RESET = 1'b0;
    end
    RESET = 1'b0;
    cyc(4'b0000, 1'b0);

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
